sara_spec_ctrl: RTL and testbench
=================================

Name:
sara_spec_ctrl

Overview:
- Speculate-and-correct controller for the segmented approximate adder (SARA datapath: per-group `select` chooses exact vs speculative group carry).
- Accepts operand transactions, drives the external combinational SARA instance with a speculative select mask, and detects carry misspeculation per group.
- On misspeculation, reissues the add with the faulty groups forced exact, then returns the result over a valid/ready handshake.
- Also maintains saturating operation and correction statistics.

Parameters:
- SIZE, 32, operand width; must be a multiple of GROUP_SIZE.
- GROUP_SIZE, 4, bits per group; must be ≥ 2.
- NG, SIZE/GROUP_SIZE, number of groups (derived, not overridable).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  controller can accept an operand transaction.
- in_a  in  SIZE  operand A; bit index 1..SIZE, LSB = 1.
- in_b  in  SIZE  operand B; indexed as in_a.
- in_cin  in  1  carry in.
- in_mode  in  2  0 = approximate only, 1 = always exact, 2 = speculate-and-correct, 3 = reserved (treated as 2).
- cfg_select  in  NG  base speculation mask for modes 0 and 2 (1 = group exact).
- sara_a, sara_b  out  SIZE  operands driven to the SARA instance.
- sara_cin  out  1  carry in driven to the SARA instance.
- sara_select  out  NG  select mask driven to the SARA instance.
- sara_sum  in  SIZE  sum returned by the SARA instance.
- sara_cout  in  1  carry out returned by the SARA instance.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  SIZE  result sum.
- out_cout  out  1  result carry out.
- out_inexact  out  1  result may be wrong (mode 0 with a detected error).
- out_fixed  out  1  result was produced by a correction pass.
- stats_clr  in  1  synchronous clear of both counters.
- op_count  out  CNT_W  completed transactions, saturating.
- fix_count  out  CNT_W  correction passes performed, saturating.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_inexact=0, out_fixed=0, counters=0, sara_* outputs=0. A reset in any state aborts the in-flight transaction with no output.
- IDLE: in_ready=1. On in_valid, register a, b, cin, mode and cfg_select, then go to SPEC. in_ready=0 in every other state.
- SPEC (one cycle):
  - Drive sara_* from the registers. sara_select = all ones in mode 1, otherwise the registered cfg_select.
  - Capture sara_sum/sara_cout and compute err[1..NG] from the registered operands:
    - p[k]=a[k]^b[k]; g[k]=a[k]&b[k].
    - c[i] = exact carry out of group i, chained from cin.
    - For i<NG: err[i] = ~sel[i] & (g[i*G]^c[i]) & p[i*G+1].
    - err[NG] = ~sel[NG] & (g[SIZE]^c[NG]).
  - Mode 2 with any err set: go to FIX. Otherwise go to HOLD, with out_inexact = (mode 0 and any err) and out_fixed=0.
- FIX (one cycle):
  - Drive sara_select = sel | err.
  - Capture the sum; the result is guaranteed exact.
  - Set out_fixed=1, out_inexact=0, increment fix_count, go to HOLD.
- HOLD:
  - out_valid=1; out_* stay stable until out_ready.
  - On out_ready: increment op_count, out_valid=0 next cycle, go to IDLE.
- Latency: accept at edge T → out_valid from T+2 (no correction) or T+3 (correction). Peak throughput is one transaction per 3 cycles.
- Counters:
  - Both saturate at 2^CNT_W−1.
  - stats_clr has priority over a same-cycle increment: the result is 0.
  - Clearing does not disturb the FSM.
- sara_* outputs hold their last values in IDLE and HOLD.

Test Plan:
1. Mode 2, a=0x0000001F, b=0x00000001, cin=0, cfg_select=0 → SPEC sees sara_sum=0x00000000 with err[1]=1; FIX drives sara_select=0x01; out_sum=0x00000020, out_fixed=1, out_valid 3 cycles after accept, fix_count=1.
2. Mode 2, a=0x0000000F, b=0x00000001, cfg_select=0 → no error (p[5]=0); out_sum=0x00000010, out_fixed=0, out_valid 2 cycles after accept.
3. Mode 0, same operands as scenario 1 → out_sum=0x00000000, out_inexact=1, no FIX pass, fix_count unchanged.
4. Mode 1, a=0xFFFFFFFF, b=0x00000001 → sara_select=0xFF, out_sum=0, out_cout=1; mode 2 with cfg_select=0 gives the same result via FIX with err[8]=1.
5. Hold out_ready=0 for 5 cycles in HOLD → out_* stable, in_ready=0, a new in_valid is ignored; out_ready=1 → op_count increments and in_ready=1 on the next cycle.
6. Assert rst during FIX → next cycle IDLE, out_valid=0, counters=0. Preload counters to the maximum value and complete an op → counters stay at the maximum value. stats_clr together with a completion → 0.

Source files
------------

// File: rtl/sara_spec_ctrl.sv
// sara_spec_ctrl: speculate-and-correct controller for an external segmented
// approximate adder (SARA). Each operand transaction is issued once with a
// speculative group-select mask. The controller recomputes the exact group
// carries to find misspeculated group boundaries. In correction mode it
// reissues the add with the faulty groups forced exact. The result is then
// returned over a valid/ready handshake.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; in_a, in_b, in_cin, in_mode
//   cfg_select        base speculation mask (1 = group exact)
//   sara_a/b/cin/select  operands and mask driven to the SARA instance
//   sara_sum/cout     result returned by the SARA instance
//   out_valid/out_ready  result handshake; out_sum, out_cout,
//                     out_inexact (approximate result may be wrong),
//                     out_fixed (result came from a correction pass)
//   stats_clr         synchronous clear of op_count and fix_count
//   op_count          completed transactions, saturating
//   fix_count         correction passes, saturating
module sara_spec_ctrl #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned GROUP_SIZE = 4,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned NG        = SIZE / GROUP_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_a,
  input  logic [SIZE-1:0]  in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_mode,
  input  logic [NG-1:0]    cfg_select,
  output logic [SIZE-1:0]  sara_a,
  output logic [SIZE-1:0]  sara_b,
  output logic             sara_cin,
  output logic [NG-1:0]    sara_select,
  input  logic [SIZE-1:0]  sara_sum,
  input  logic             sara_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_sum,
  output logic             out_cout,
  output logic             out_inexact,
  output logic             out_fixed,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] fix_count
);

  localparam logic [1:0] MODE_APPROX = 2'd0;
  localparam logic [1:0] MODE_EXACT  = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPEC,
    S_FIX,
    S_HOLD
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [NG-1:0]   err;
  logic            any_err;
  logic            op_done;
  logic            fix_done;

  // Misspeculation detection. The sara_* registers double as the operand
  // registers, so err is evaluated against exactly what the adder sees.
  // A boundary is wrong when the speculated carry (generate of the group
  // MSB) differs from the exact chained carry. Below the top group this only
  // matters if the next group's LSB propagates.
  always_comb begin : err_calc
    logic [SIZE:0]   cy;
    logic [SIZE-1:0] p;
    logic [SIZE-1:0] g;
    p     = sara_a ^ sara_b;
    g     = sara_a & sara_b;
    cy    = '0;
    cy[0] = sara_cin;
    for (int unsigned k = 0; k < SIZE; k++) begin
      cy[k+1] = g[k] | (p[k] & cy[k]);
    end
    err = '0;
    for (int unsigned i = 0; i + 1 < NG; i++) begin
      err[i] = ~sara_select[i]
             & (g[(i+1)*GROUP_SIZE-1] ^ cy[(i+1)*GROUP_SIZE])
             & p[(i+1)*GROUP_SIZE];
    end
    err[NG-1] = ~sara_select[NG-1] & (g[SIZE-1] ^ cy[SIZE]);
  end

  assign any_err  = |err;
  assign op_done  = (state == S_HOLD) && out_ready;
  assign fix_done = (state == S_FIX);

  // Transaction FSM with registered handshake, SARA drive and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= MODE_APPROX;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_cout    <= 1'b0;
      out_inexact <= 1'b0;
      out_fixed   <= 1'b0;
      sara_a      <= '0;
      sara_b      <= '0;
      sara_cin    <= 1'b0;
      sara_select <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sara_a      <= in_a;
            sara_b      <= in_b;
            sara_cin    <= in_cin;
            sara_select <= (in_mode == MODE_EXACT) ? '1 : cfg_select;
            mode_q      <= in_mode;
            in_ready    <= 1'b0;
            state       <= S_SPEC;
          end
        end
        S_SPEC: begin
          // Modes 2 and 3 both correct; mode 0 only flags the error.
          if (mode_q[1] && any_err) begin
            sara_select <= sara_select | err;
            state       <= S_FIX;
          end else begin
            out_sum     <= sara_sum;
            out_cout    <= sara_cout;
            out_inexact <= (mode_q == MODE_APPROX) && any_err;
            out_fixed   <= 1'b0;
            out_valid   <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_FIX: begin
          // Every faulty boundary is now exact, so this sum is the true one.
          out_sum     <= sara_sum;
          out_cout    <= sara_cout;
          out_inexact <= 1'b0;
          out_fixed   <= 1'b1;
          out_valid   <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      op_count  <= '0;
      fix_count <= '0;
    end else begin
      if (op_done && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (fix_done && (fix_count != {CNT_W{1'b1}})) begin
        fix_count <= fix_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sara_spec_ctrl.sv
// Testbench for sara_spec_ctrl with a behavioural SARA model and a result
// scoreboard. Counters are narrowed to 4 bits so saturation is reachable.
module tb_sara_spec_ctrl;

  localparam int unsigned SIZE  = 32;
  localparam int unsigned G     = 4;
  localparam int unsigned NG    = SIZE / G;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        inexact;
    logic        fixed;
    logic [3:0]  lat;
  } res_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_a;
  logic [SIZE-1:0]  in_b;
  logic             in_cin;
  logic [1:0]       in_mode;
  logic [NG-1:0]    cfg_select;
  logic [SIZE-1:0]  sara_a;
  logic [SIZE-1:0]  sara_b;
  logic             sara_cin;
  logic [NG-1:0]    sara_select;
  logic [SIZE-1:0]  sara_sum;
  logic             sara_cout;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_sum;
  logic             out_cout;
  logic             out_inexact;
  logic             out_fixed;
  logic             stats_clr;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] fix_count;

  int   n_checks;
  int   n_fail;
  int   exp_ops;
  int   exp_fix;
  res_t sbq[$];

  sara_spec_ctrl #(.SIZE(SIZE), .GROUP_SIZE(G), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
    .cfg_select(cfg_select),
    .sara_a(sara_a), .sara_b(sara_b), .sara_cin(sara_cin),
    .sara_select(sara_select), .sara_sum(sara_sum), .sara_cout(sara_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .out_inexact(out_inexact), .out_fixed(out_fixed),
    .stats_clr(stats_clr), .op_count(op_count), .fix_count(fix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference error vector, using masked integer sums for the group carries.
  function automatic logic [NG-1:0] ref_err(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic [NG-1:0] sel);
    logic [63:0]   mask;
    logic [63:0]   s;
    logic [NG-1:0] e;
    int            hi;
    e = '0;
    for (int i = 1; i <= int'(NG); i++) begin
      hi   = i * int'(G);
      mask = (64'd1 << hi) - 64'd1;
      s    = ({32'd0, a} & mask) + ({32'd0, b} & mask) + 64'(cin);
      if (i < int'(NG))
        e[i-1] = ~sel[i-1] & ((a[hi-1] & b[hi-1]) ^ s[hi]) & (a[hi] ^ b[hi]);
      else
        e[i-1] = ~sel[i-1] & ((a[hi-1] & b[hi-1]) ^ s[hi]);
    end
    return e;
  endfunction

  // Behavioural SARA: exact sum, with the group above each misspeculated
  // boundary corrupted to zero and a speculated top carry.
  function automatic logic [32:0] sara_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic cin, input logic [NG-1:0] sel);
    logic [32:0]   r;
    logic [NG-1:0] e;
    r = 33'(a) + 33'(b) + 33'(cin);
    e = ref_err(a, b, cin, sel);
    for (int i = 0; i < int'(NG) - 1; i++) begin
      if (e[i]) r[(i+1)*int'(G) +: G] = '0;
    end
    if (e[NG-1]) r[SIZE] = a[SIZE-1] & b[SIZE-1];
    return r;
  endfunction

  always_comb {sara_cout, sara_sum} = sara_model(sara_a, sara_b, sara_cin, sara_select);

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic [1:0] mode, input logic [NG-1:0] cfg);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    in_a = a; in_b = b; in_cin = cin; in_mode = mode; cfg_select = cfg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called one step after the accept edge; latency counts from that edge.
  task automatic collect(output res_t o, output logic [NG-1:0] sel_spec,
                         output logic [NG-1:0] sel_next);
    int lat;
    sel_spec = sara_select;
    sel_next = sara_select;
    lat = 1;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 2) sel_next = sara_select;
    end while (out_valid !== 1'b1 && lat < 15);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL collect_timeout out_valid=%b want 1", out_valid);
    end
    o = '{sum: out_sum, cout: out_cout, inexact: out_inexact, fixed: out_fixed,
          lat: 4'(lat)};
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_ops < CMAX) exp_ops++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_cout, out_inexact, out_fixed} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 10000",
               {in_ready, out_valid, out_cout, out_inexact, out_fixed});
    end
    n_checks++;
    if (out_sum !== 32'd0) begin n_fail++; $display("FAIL reset_sum got %h want 0", out_sum); end
    n_checks++;
    if ({sara_a, sara_b, sara_cin, sara_select} !== '0) begin
      n_fail++;
      $display("FAIL reset_sara got %h %h %b %h want 0", sara_a, sara_b, sara_cin, sara_select);
    end
    n_checks++;
    if (op_count !== 4'd0 || fix_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", op_count, fix_count);
    end
  endtask

  task automatic test_fix_path();
    res_t e, o; logic [NG-1:0] ss, sn;
    sbq.push_back('{sum: 32'h20, cout: 1'b0, inexact: 1'b0, fixed: 1'b1, lat: 4'd3});
    send(32'h1F, 32'h1, 1'b0, 2'd2, 8'h00);
    collect(o, ss, sn);
    e = sbq.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL fix_result got %h want %h", o, e); end
    n_checks++;
    if (ss !== 8'h00 || sn !== 8'h01) begin
      n_fail++;
      $display("FAIL fix_select got %h/%h want 00/01", ss, sn);
    end
    handshake();
    exp_fix++;
    n_checks++;
    if (fix_count !== 4'(exp_fix) || op_count !== 4'(exp_ops)) begin
      n_fail++;
      $display("FAIL fix_counts got %0d/%0d want %0d/%0d", fix_count, op_count, exp_fix, exp_ops);
    end
  endtask

  task automatic test_no_error();
    res_t e, o; logic [NG-1:0] ss, sn;
    sbq.push_back('{sum: 32'h10, cout: 1'b0, inexact: 1'b0, fixed: 1'b0, lat: 4'd2});
    send(32'h0F, 32'h1, 1'b0, 2'd2, 8'h00);
    collect(o, ss, sn);
    e = sbq.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL noerr_result got %h want %h", o, e); end
    handshake();
  endtask

  task automatic test_approx();
    res_t e, o; logic [NG-1:0] ss, sn;
    sbq.push_back('{sum: 32'h00, cout: 1'b0, inexact: 1'b1, fixed: 1'b0, lat: 4'd2});
    send(32'h1F, 32'h1, 1'b0, 2'd0, 8'h00);
    collect(o, ss, sn);
    e = sbq.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL approx_result got %h want %h", o, e); end
    handshake();
    n_checks++;
    if (fix_count !== 4'(exp_fix)) begin
      n_fail++;
      $display("FAIL approx_fixcount got %0d want %0d", fix_count, exp_fix);
    end
  endtask

  task automatic test_exact();
    res_t e, o; logic [NG-1:0] ss, sn;
    sbq.push_back('{sum: 32'h0, cout: 1'b1, inexact: 1'b0, fixed: 1'b0, lat: 4'd2});
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 2'd1, 8'h00);
    collect(o, ss, sn);
    e = sbq.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL exact_result got %h want %h", o, e); end
    n_checks++;
    if (ss !== 8'hFF) begin n_fail++; $display("FAIL exact_select got %h want ff", ss); end
    handshake();
    // Same operands corrected: every boundary including the top one is wrong.
    for (int m = 2; m <= 3; m++) begin
      sbq.push_back('{sum: 32'h0, cout: 1'b1, inexact: 1'b0, fixed: 1'b1, lat: 4'd3});
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 2'(m), 8'h00);
      collect(o, ss, sn);
      e = sbq.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL spec_top_result mode=%0d got %h want %h", m, o, e); end
      n_checks++;
      if (sn !== 8'hFF) begin n_fail++; $display("FAIL spec_top_fixsel mode=%0d got %h want ff", m, sn); end
      handshake();
      exp_fix++;
    end
  endtask

  task automatic test_backpressure();
    res_t e, o; logic [NG-1:0] ss, sn;
    sbq.push_back('{sum: 32'h10, cout: 1'b0, inexact: 1'b0, fixed: 1'b0, lat: 4'd2});
    send(32'h0F, 32'h1, 1'b0, 2'd2, 8'h00);
    collect(o, ss, sn);
    e = sbq.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL bp_result got %h want %h", o, e); end
    in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_mode = 2'd1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, out_sum, out_cout, out_inexact, out_fixed} !==
          {1'b1, 1'b0, e.sum, e.cout, e.inexact, e.fixed}) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v=%b r=%b sum=%h want v=1 r=0 sum=%h",
                 c, out_valid, in_ready, out_sum, e.sum);
      end
    end
    in_valid = 1'b0;
    handshake();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01 || op_count !== 4'(exp_ops) || sara_a !== 32'h0F) begin
      n_fail++;
      $display("FAIL bp_release got v=%b r=%b ops=%0d sara_a=%h want v=0 r=1 ops=%0d sara_a=0000000f",
               out_valid, in_ready, op_count, sara_a, exp_ops);
    end
  endtask

  task automatic test_reset_in_fix();
    send(32'h1F, 32'h1, 1'b0, 2'd2, 8'h00);
    @(posedge clk); #1;
    n_checks++;
    if (sara_select !== 8'h01) begin n_fail++; $display("FAIL rstfix_select got %h want 01", sara_select); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ops = 0; exp_fix = 0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01 || op_count !== 4'd0 || fix_count !== 4'd0) begin
      n_fail++;
      $display("FAIL rstfix_state got v=%b r=%b ops=%0d fix=%0d want v=0 r=1 0/0",
               out_valid, in_ready, op_count, fix_count);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfix_no_output got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    res_t e, o; logic [NG-1:0] ss, sn, sel, er;
    logic [31:0] a, b; logic cin; logic [1:0] mode; logic [32:0] r;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(1));
      mode = (i < 14) ? 2'd2 : 2'($urandom_range(3));
      sel = 8'($urandom) & 8'($urandom);
      if (mode == 2'd1) sel = 8'hFF;
      er = ref_err(a, b, cin, sel);
      if (mode[1] && er != 0) begin
        r = 33'(a) + 33'(b) + 33'(cin);
        e = '{sum: r[31:0], cout: r[32], inexact: 1'b0, fixed: 1'b1, lat: 4'd3};
        if (exp_fix < CMAX) exp_fix++;
      end else begin
        r = sara_model(a, b, cin, sel);
        e = '{sum: r[31:0], cout: r[32], inexact: (mode == 2'd0) && (er != 0),
              fixed: 1'b0, lat: 4'd2};
      end
      sbq.push_back(e);
      send(a, b, cin, mode, mode == 2'd1 ? 8'($urandom) : sel);
      collect(o, ss, sn);
      e = sbq.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rand_result i=%0d got %h want %h", i, o, e); end
      handshake();
    end
    n_checks++;
    if (op_count !== 4'(exp_ops) || fix_count !== 4'(exp_fix)) begin
      n_fail++;
      $display("FAIL sat_counts got %0d/%0d want %0d/%0d", op_count, fix_count, exp_ops, exp_fix);
    end
  endtask

  task automatic test_stats_clr();
    res_t e, o; logic [NG-1:0] ss, sn;
    sbq.push_back('{sum: 32'h20, cout: 1'b0, inexact: 1'b0, fixed: 1'b1, lat: 4'd3});
    send(32'h1F, 32'h1, 1'b0, 2'd3, 8'h00);
    collect(o, ss, sn);
    e = sbq.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL clr_result got %h want %h", o, e); end
    stats_clr = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (op_count !== 4'd0 || fix_count !== 4'd0 || out_valid !== 1'b1 || out_sum !== 32'h20) begin
      n_fail++;
      $display("FAIL clr_hold got ops=%0d fix=%0d v=%b sum=%h want 0/0 v=1 sum=00000020",
               op_count, fix_count, out_valid, out_sum);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; stats_clr = 1'b0;
    n_checks++;
    if (op_count !== 4'd0 || {out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL clr_with_done got ops=%0d v=%b r=%b want 0 v=0 r=1", op_count, out_valid, in_ready);
    end
    exp_ops = 0; exp_fix = 0;
    sbq.push_back('{sum: 32'h10, cout: 1'b0, inexact: 1'b0, fixed: 1'b0, lat: 4'd2});
    send(32'h0F, 32'h1, 1'b0, 2'd2, 8'h00);
    collect(o, ss, sn);
    e = sbq.pop_front();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL clr_after_result got %h want %h", o, e); end
    handshake();
    n_checks++;
    if (op_count !== 4'(exp_ops) || fix_count !== 4'(exp_fix)) begin
      n_fail++;
      $display("FAIL clr_after_counts got %0d/%0d want %0d/%0d", op_count, fix_count, exp_ops, exp_fix);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_ops = 0; exp_fix = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_mode = 2'd0; cfg_select = '0; out_ready = 1'b0; stats_clr = 1'b0;
    test_reset();
    test_fix_path();
    test_no_error();
    test_approx();
    test_exact();
    test_backpressure();
    test_reset_in_fix();
    test_saturation();
    test_stats_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
